// File: rtl/clk_pulse_train_if.sv
// Bundle of the div_clk sample, burst request and burst status signals.
// Defining CLK_PULSE_TRAIN_ABORT_EN adds the abort/aborted pair.
interface clk_pulse_train_if #(parameter int CNT_W = 8);
    logic             div_clk;
    logic             start;
    logic [CNT_W-1:0] num_pulses;
    logic             tick_rise;
    logic             tick_fall;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    modport master (
`ifdef CLK_PULSE_TRAIN_ABORT_EN
        output abort,
        input  aborted,
`endif
        output div_clk, start, num_pulses,
        input  tick_rise, tick_fall, pulse_out, busy, done, pulses_left
    );

    modport slave (
`ifdef CLK_PULSE_TRAIN_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  div_clk, start, num_pulses,
        output tick_rise, tick_fall, pulse_out, busy, done, pulses_left
    );
endinterface

// File: rtl/clk_pulse_train.sv
// Burst of N pulses aligned to div_clk high phases; div_clk is sampled as data.
// Optional abort support under CLK_PULSE_TRAIN_ABORT_EN.
module clk_pulse_train #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    clk_pulse_train_if.slave pif
);
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

    state_e           state_q, state_d;
    logic             div_q, primed_q;
    logic             rise, fall;
    logic             tick_rise_q, tick_fall_q;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] left_q, left_d;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    // primed masks the first post-reset cycle, when div_q does not yet hold a real sample
    assign rise = primed_q &  pif.div_clk & ~div_q;
    assign fall = primed_q & ~pif.div_clk &  div_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= 1'b0;
            primed_q    <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
        end else begin
            div_q       <= pif.div_clk;
            primed_q    <= 1'b1;
            tick_rise_q <= rise;
            tick_fall_q <= fall;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            left_q    <= '0;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            left_q    <= left_d;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pulse_d   = pulse_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        left_d    = left_q;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pif.start) begin
                    if (pif.num_pulses != '0) begin
                        left_d  = pif.num_pulses;
                        busy_d  = 1'b1;
                        state_d = ARM;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ARM, LOW: begin
                // ARM waits for a rise so the first pulse is never truncated
                if (rise) begin
                    pulse_d = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    pulse_d = 1'b0;
                    left_d  = left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef CLK_PULSE_TRAIN_ABORT_EN
        // abort overrides whatever edge handling happened above
        if (pif.abort && state_q != IDLE) begin
            state_d   = IDLE;
            pulse_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            left_d    = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    assign pif.tick_rise   = tick_rise_q;
    assign pif.tick_fall   = tick_fall_q;
    assign pif.pulse_out   = pulse_q;
    assign pif.busy        = busy_q;
    assign pif.done        = done_q;
    assign pif.pulses_left = left_q;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
    assign pif.aborted     = aborted_q;
`endif
endmodule

// File: tb/tb_clk_pulse_train.sv
// Scoreboarded bench for clk_pulse_train: expected pulse counts are queued at
// start and checked at done; a tick model and pulse monitor run throughout.
module tb_clk_pulse_train;
    logic clk = 1'b0;
    logic rst = 1'b0;

    clk_pulse_train_if #(.CNT_W(8)) pif ();
    clk_pulse_train #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .pif(pif.slave));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // div_clk generator (2 high / 2 low) plus history of what the DUT sampled
    logic       div_en = 1'b0;
    logic [1:0] ph     = 2'd3;
    logic       h1 = 1'b0, h2 = 1'b0, prim_l = 1'b0, rst_pe = 1'b0;
    always @(posedge clk) begin
        h2     = h1;
        h1     = pif.div_clk;
        prim_l = rst_pe;
        rst_pe = rst;
        #1;
        if (div_en) begin
            ph          = ph + 2'd1;
            pif.div_clk = ph[1];
        end
    end

    logic       prev_po = 1'b0;
    logic [7:0] prev_left = 8'd0;
    logic       abt;
    int         pw = 0, npul = 0, e = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_po = 1'b0; prev_left = 8'd0; pw = 0; npul = 0;
        end else begin
            chk("tick_rise", 32'(pif.tick_rise), 32'(prim_l & h1 & ~h2));
            chk("tick_fall", 32'(pif.tick_fall), 32'(prim_l & ~h1 & h2));
`ifdef CLK_PULSE_TRAIN_ABORT_EN
            abt = pif.aborted;
`else
            abt = 1'b0;
`endif
            if (abt) begin
                chk("abort_sb", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) e = sb.pop_front();
                npul = 0; pw = 0;
            end else begin
                if (pif.pulse_out && !prev_po) begin
                    chk("po_rise_tick", 32'(pif.tick_rise), 1);
                    pw = 1;
                end else if (pif.pulse_out) begin
                    pw++;
                end
                if (!pif.pulse_out && prev_po) begin
                    chk("po_fall_tick", 32'(pif.tick_fall), 1);
                    chk("pulse_w", pw, 2);
                    chk("left_dec", 32'(pif.pulses_left), 32'(8'(prev_left - 8'd1)));
                    npul++;
                end
                if (pif.done) begin
                    chk("done_busy", 32'(pif.busy), 0);
                    chk("done_left", 32'(pif.pulses_left), 0);
                    chk("done_sb", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("npulses", npul, e);
                        if (e != 0) chk("done_fall", 32'({prev_po, pif.pulse_out}), 2);
                    end
                    npul = 0;
                end
            end
            prev_po   = pif.pulse_out;
            prev_left = pif.pulses_left;
        end
    end

    function automatic logic [12:0] outs();
        return {pif.tick_rise, pif.tick_fall, pif.pulse_out, pif.busy, pif.done, pif.pulses_left};
    endfunction

    // caller sits at a negedge; returns one negedge after the accepting edge
    task automatic do_start(input int n);
        pif.start      = 1'b1;
        pif.num_pulses = 8'(n);
        sb.push_back(n);
        @(negedge clk);
        pif.start      = 1'b0;
        pif.num_pulses = 8'($urandom);
        if (n != 0) begin
            chk("busy_acc", 32'(pif.busy), 1);
            chk("left_latch", 32'(pif.pulses_left), 32'(n));
        end else begin
            chk("done_zero", 32'(pif.done), 1);
            chk("busy_zero", 32'(pif.busy), 0);
        end
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!pif.done && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(pif.done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc, fc, lr, bad, k;
        pif.div_clk = 1'b1; pif.start = 1'b0; pif.num_pulses = 8'd0;
`ifdef CLK_PULSE_TRAIN_ABORT_EN
        pif.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'(outs()), 0);

        // release with div_clk held high: no tick on the first edge
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("first_tick", 32'({pif.tick_rise, pif.tick_fall}), 0);

        div_en = 1'b1;
        rc = 0; fc = 0; lr = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pif.tick_rise) begin
                if (lr >= 0) chk("rise_gap", i - lr, 4);
                lr = i; rc++;
            end
            if (pif.tick_fall) begin
                if (lr >= 0) chk("rise_fall_gap", i - lr, 2);
                fc++;
            end
        end
        chk("rise_cnt", rc, 4);
        chk("fall_cnt", fc, 4);

        // 3-pulse burst, then a back-to-back start right at done
        do_start(3);
        wait_done(60);
        do_start(2);
        wait_done(60);

        // zero-length request
        @(negedge clk);
        do_start(0);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            bad += int'(pif.pulse_out | pif.busy | pif.done);
        end
        chk("zero_quiet", bad, 0);

        // start while div_clk high; a second start during busy is ignored
        k = 0;
        while (!pif.div_clk && k < 8) begin @(negedge clk); k++; end
        do_start(1);
        @(negedge clk);
        pif.start = 1'b1; pif.num_pulses = 8'd4;
        @(negedge clk);
        pif.start = 1'b0;
        wait_done(40);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            bad += int'(pif.busy | pif.pulse_out);
        end
        chk("no_restart", bad, 0);

        // reset during pulse 2 of 5
        do_start(5);
        k = 0;
        while (!(pif.pulses_left == 8'd4 && pif.pulse_out) && k < 40) begin @(negedge clk); k++; end
        chk("reach_p2", 32'(pif.pulses_left == 8'd4 && pif.pulse_out), 1);
        #2 rst = 1'b0;
        sb.delete();
        #1 chk("async_rst", 32'(outs()), 0);
        repeat (2) @(negedge clk);
        chk("rst_hold", 32'(outs()), 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_start(2);
        wait_done(40);

`ifdef CLK_PULSE_TRAIN_ABORT_EN
        @(negedge clk);
        do_start(4);
        k = 0;
        while (!(pif.pulses_left == 8'd3 && pif.pulse_out) && k < 40) begin @(negedge clk); k++; end
        chk("reach_h2", 32'(pif.pulses_left == 8'd3 && pif.pulse_out), 1);
        pif.abort = 1'b1;
        @(negedge clk);
        pif.abort = 1'b0;
        chk("ab_flag", 32'(pif.aborted), 1);
        chk("ab_po", 32'(pif.pulse_out), 0);
        chk("ab_busy", 32'(pif.busy), 0);
        chk("ab_left", 32'(pif.pulses_left), 0);
        chk("ab_done", 32'(pif.done), 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            bad += int'(pif.done | pif.aborted | pif.busy);
        end
        chk("ab_quiet", bad, 0);
        pif.abort = 1'b1;
        @(negedge clk);
        pif.abort = 1'b0;
        @(negedge clk);
        chk("ab_idle", 32'(pif.aborted), 0);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_pulse_train.md
Name: clk_pulse_train

Overview:
- Downstream consumer of the divided clock produced by the team's clock divider.
- Samples `div_clk` as a data signal in the `clk` domain and generates registered single-cycle rise/fall ticks.
- On `start`, emits a burst of N pulses, each aligned to one `div_clk` high phase, with a busy/done handshake.
- Used to clock out serial frames (shift strobes, chip selects) at the divided rate without driving logic from a derived clock.

Parameters:
- CNT_W, 8, width of the pulse-count request and the remaining-count output.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset: asynchronous, active-low.
- div_clk  input  1  divided clock from the clock divider, synchronous to clk; treated as data.
- start  input  1  burst request; sampled only in IDLE.
- num_pulses  input  CNT_W  pulses to emit; latched when start is accepted.
- tick_rise  output  1  one-cycle strobe per detected div_clk rising edge.
- tick_fall  output  1  one-cycle strobe per detected div_clk falling edge.
- pulse_out  output  1  burst output, registered.
- busy  output  1  high from start acceptance until burst completion.
- done  output  1  one-cycle strobe when a burst completes.
- pulses_left  output  CNT_W  pulses still to be completed, counting the one in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: every output 0; div_q 0; primed 0; state IDLE.
- Edge detect:
  - div_q <= div_clk every cycle.
  - primed goes to 1 on the first clock after reset release.
  - Combinational rise = primed & div_clk & ~div_q; fall = primed & ~div_clk & div_q.
  - No tick is ever generated on the first post-reset cycle, whatever level div_clk has.
- tick_rise <= rise and tick_fall <= fall: registered, 1 cycle wide.
- Ticks run in every state, independent of the FSM.
- FSM states: IDLE, ARM, HIGH, LOW.
- IDLE:
  - start=1 and num_pulses!=0: latch pulses_left=num_pulses, busy<=1, go to ARM.
  - start=1 and num_pulses==0: done<=1 for 1 cycle, busy stays 0, stay in IDLE, no pulses.
- ARM:
  - Wait for rise; a burst never starts mid-phase.
  - On rise: pulse_out<=1, go to HIGH.
- HIGH, on fall:
  - pulse_out<=0, pulses_left<=pulses_left-1.
  - If pulses_left==1: busy<=0, done<=1, go to IDLE.
  - Otherwise go to LOW.
- LOW, on rise: pulse_out<=1, go to HIGH.
- Timing:
  - pulse_out rises in the same cycle as tick_rise and falls in the same cycle as tick_fall.
  - Each pulse width equals the div_clk high time in clk cycles.
- done and busy=0 appear in the same cycle as the final pulse_out falling.
- A new start is accepted on the cycle after done (state is back in IDLE).
- start while busy=1 is ignored; num_pulses changes while busy have no effect.
- pulses_left never wraps; it is decremented only from HIGH with value >=1.
- rst asserted mid-burst: pulse_out drops asynchronously; no done is produced.
- If div_clk stops toggling, the FSM holds its state indefinitely; there is no timeout.

Optional Feature:
- Macro: CLK_PULSE_TRAIN_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit).
  - abort=1 in ARM/HIGH/LOW: next cycle pulse_out=0, busy=0, pulses_left=0, state IDLE, aborted=1 for 1 cycle, done stays 0.
  - abort has priority over a simultaneous fall/rise.
  - abort in IDLE is ignored; abort and start in the same IDLE cycle: start wins.
- When undefined: neither port exists; a burst always runs to completion or reset.

Test Plan:
- Reset release with div_clk held 1, then div_clk toggled at period 4 (2 high/2 low) -> no tick on the first cycle; thereafter tick_rise/tick_fall each 1 cycle wide, 4 cycles apart, 2 cycles offset.
- div_clk period 4, start with num_pulses=3 -> exactly 3 pulse_out pulses, each 2 cycles wide; pulses_left 3→2→1→0; done for 1 cycle coincident with the third fall; busy low in that same cycle.
- start with num_pulses=0 -> done high 1 cycle later, busy never asserts, pulse_out stays 0.
- start asserted while div_clk is high, num_pulses=1 -> pulse_out waits for the next rise (no truncated pulse); a second start during busy is ignored and produces 1 pulse total.
- Burst num_pulses=5, rst low during pulse 2 -> all outputs 0 asynchronously; after release with start and num_pulses=2, exactly 2 pulses.
- With CLK_PULSE_TRAIN_ABORT_EN, num_pulses=4, abort during the second HIGH -> pulse_out low next cycle, aborted 1 cycle, done never asserts, pulses_left=0.
